// File: rtl/fib_pkg.sv
// Shared definitions for the generalised-Fibonacci engine.
// Holds the FSM state encoding and the mode select constants.
package fib_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: W-bit sum of the two current terms plus its carry-out.
module fib_step #(
   parameter int W = 20
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_gen.sv
// Generalised-Fibonacci engine: returns F(i) or streams F(0..i) for arbitrary
// seeds, with sticky carry-out overflow detection and abort.
module fib_gen
   import fib_pkg::*;
#(
   parameter int W  = 20,
   parameter int NW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          mode,
   input  logic [NW-1:0] i,
   input  logic [W-1:0]  seed0,
   input  logic [W-1:0]  seed1,
   input  logic          out_ready,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic          out_valid,
   output logic [W-1:0]  f,
   output logic          ovf
);

   state_t        state, state_nxt;
   logic [W-1:0]  a, a_nxt, b, b_nxt, sum;
   logic [NW-1:0] k, k_nxt, i_cap, i_cap_nxt;
   logic          mode_cap, mode_cap_nxt, ovf_r, ovf_nxt;
   logic          carry, last, step_ovf;

   fib_step #(.W(W)) u_step (
      .a     (a),
      .b     (b),
      .sum   (sum),
      .carry (carry)
   );

   assign last = (k == i_cap);
   // The new b is F(k+2); a carry only matters if that term is within the sequence.
   assign step_ovf = carry && (({1'b0, k} + (NW+1)'(2)) <= {1'b0, i_cap});

   always_comb begin
      state_nxt    = state;
      a_nxt        = a;
      b_nxt        = b;
      k_nxt        = k;
      i_cap_nxt    = i_cap;
      mode_cap_nxt = mode_cap;
      ovf_nxt      = ovf_r;
      unique case (state)
         IDLE: begin
            if (start) begin
               a_nxt        = seed0;
               b_nxt        = seed1;
               k_nxt        = '0;
               ovf_nxt      = 1'b0;
               i_cap_nxt    = i;
               mode_cap_nxt = mode;
               state_nxt    = (mode == MODE_STREAM) ? STREAM : CALC;
            end
         end
         CALC, STREAM: begin
            if (abort) begin
               ovf_nxt   = 1'b0;
               state_nxt = IDLE;
            end else if (state == CALC || out_ready) begin
               if (last) begin
                  state_nxt = DONE;
               end else begin
                  a_nxt = b;
                  b_nxt = sum;
                  k_nxt = k + NW'(1);
                  if (step_ovf) ovf_nxt = 1'b1;
               end
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         a        <= '0;
         b        <= '0;
         k        <= '0;
         i_cap    <= '0;
         mode_cap <= MODE_SINGLE;
         ovf_r    <= 1'b0;
      end else begin
         state    <= state_nxt;
         a        <= a_nxt;
         b        <= b_nxt;
         k        <= k_nxt;
         i_cap    <= i_cap_nxt;
         mode_cap <= mode_cap_nxt;
         ovf_r    <= ovf_nxt;
      end
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == CALC) || (state == STREAM);
   assign done      = (state == DONE);
   assign out_valid = (state == STREAM) && (mode_cap == MODE_STREAM);
   assign f         = a;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_fib_gen.sv
// Directed bench for fib_gen: expected results are queued at start and
// compared when the engine reports them (done pulse or stream handshake).
module tb_fib_gen;

   localparam int W  = 20;
   localparam int NW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          mode = 1'b0;
   logic          out_ready = 1'b0;
   logic [NW-1:0] i = '0;
   logic [W-1:0]  seed0 = '0;
   logic [W-1:0]  seed1 = '0;
   logic          ready, busy, done, out_valid, ovf;
   logic [W-1:0]  f;

   typedef struct {
      logic [W-1:0] f;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fib_gen #(.W(W), .NW(NW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .i         (i),
      .seed0     (seed0),
      .seed1     (seed1),
      .out_ready (out_ready),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .f         (f),
      .ovf       (ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ":ready"}, 32'(ready), 32'd1);
      check({tag, ":busy"}, 32'(busy), 32'd0);
      check({tag, ":done"}, 32'(done), 32'd0);
      check({tag, ":out_valid"}, 32'(out_valid), 32'd0);
      check({tag, ":f"}, 32'(f), 32'd0);
      check({tag, ":ovf"}, 32'(ovf), 32'd0);
   endtask

   // Single-mode run; poke=1 fires a conflicting start while the engine is busy.
   task automatic run_single(input string tag, input logic [W-1:0] s0, input logic [W-1:0] s1,
                             input logic [NW-1:0] ii, input logic [W-1:0] ef, input logic eo,
                             input bit poke);
      int   c;
      exp_t e;
      seed0 = s0;
      seed1 = s1;
      i     = ii;
      mode  = 1'b0;
      start = 1'b1;
      sb.push_back('{ef, eo});
      tick();
      start = 1'b0;
      c = 1;
      while (!done && c < 100) begin
         if (poke && c == 2) begin
            start = 1'b1;
            i     = 5'd3;
            seed0 = 20'd9;
            seed1 = 20'd9;
         end else begin
            start = 1'b0;
         end
         tick();
         c++;
      end
      start = 1'b0;
      check({tag, ":latency"}, 32'(c), 32'(ii) + 32'd2);
      if (done && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, ":f"}, 32'(f), 32'(e.f));
         check({tag, ":ovf"}, 32'(ovf), 32'(e.ovf));
      end
      tick();
      check({tag, ":done_once"}, 32'(done), 32'd0);
      check({tag, ":ready_after"}, 32'(ready), 32'd1);
      check({tag, ":f_hold"}, 32'(f), 32'(ef));
   endtask

   initial begin
      int c;
      int pops;
      exp_t e;
      logic [W-1:0] terms [5];

      // Reset state
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b1;
      tick();

      run_single("fib10", 20'd0, 20'd1, 5'd10, 20'd55, 1'b0, 1'b0);
      run_single("fib0", 20'd0, 20'd1, 5'd0, 20'd0, 1'b0, 1'b0);
      run_single("fib1", 20'd0, 20'd1, 5'd1, 20'd1, 1'b0, 1'b0);
      run_single("lucas5", 20'd2, 20'd1, 5'd5, 20'd11, 1'b0, 1'b1);
      run_single("seed33", 20'd3, 20'd3, 5'd4, 20'd15, 1'b0, 1'b0);
      run_single("fib30", 20'd0, 20'd1, 5'd30, 20'd832040, 1'b0, 1'b0);
      run_single("fib31", 20'd0, 20'd1, 5'd31, 20'd297693, 1'b1, 1'b0);

      // Stream mode with out_ready toggling
      terms[0] = 20'd0; terms[1] = 20'd1; terms[2] = 20'd1; terms[3] = 20'd2; terms[4] = 20'd3;
      for (int n = 0; n < 5; n++) sb.push_back('{terms[n], 1'b0});
      seed0 = 20'd0; seed1 = 20'd1; i = 5'd4; mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      c = 1;
      pops = 0;
      out_ready = 1'b1;
      while (!done && c < 60) begin
         if (out_valid && sb.size() > 0) begin
            check("stream:term", 32'(f), 32'(sb[0].f));
            if (out_ready) begin
               e = sb.pop_front();
               pops++;
            end
         end
         tick();
         c++;
         out_ready = ~out_ready;
      end
      out_ready = 1'b0;
      check("stream:done_seen", 32'(done), 32'd1);
      check("stream:latency", 32'(c), 32'd10);
      check("stream:terms", 32'(pops), 32'd5);
      check("stream:out_valid_in_done", 32'(out_valid), 32'd0);
      tick();
      check("stream:done_once", 32'(done), 32'd0);
      check("stream:ready_after", 32'(ready), 32'd1);

      // Abort in cycle 5 of a long single run
      seed0 = 20'd0; seed1 = 20'd1; i = 5'd20; mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n < 5; n++) tick();
      check("abort:busy_before", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort:ready", 32'(ready), 32'd1);
      check("abort:busy", 32'(busy), 32'd0);
      check("abort:done", 32'(done), 32'd0);
      check("abort:ovf", 32'(ovf), 32'd0);
      tick();
      check("abort:no_late_done", 32'(done), 32'd0);
      run_single("after_abort", 20'd0, 20'd1, 5'd7, 20'd13, 1'b0, 1'b0);

      // Reset pulse mid-stream
      seed0 = 20'd5; seed1 = 20'd7; i = 5'd10; mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      check("rst_mid:out_valid", 32'(out_valid), 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_reset_outputs("rst_mid");
      tick();
      check("rst_mid:no_done", 32'(done), 32'd0);
      run_single("after_rst", 20'd2, 20'd1, 5'd5, 20'd11, 1'b0, 1'b0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fib_gen.md
# fib_gen

Parametrised generalised-Fibonacci sequence engine. Computes F(i) for F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2) mod 2^W. It returns either the single term or the full sequence F(0..i) as a backpressured stream, with carry-out overflow detection and abort. It sits beside the datapath controllers as a start/ready/done slave and supersedes the fixed 20-bit, fixed-seed Fibonacci unit.

## Interface
- W, 20: term width (bits); W ≥ 2
- NW, 5: index width; i ranges 0..2^NW-1
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- abort  in  1  cancel operation in CALC/STREAM; ignored elsewhere
- mode  in  1  0 = single result, 1 = stream every term
- i  in  NW  target index, captured on accept
- seed0  in  W  F(0), captured on accept
- seed1  in  W  F(1), captured on accept
- out_ready  in  1  stream sink ready (stream mode only)
- ready  out  1  high in IDLE
- busy  out  1  high in CALC or STREAM
- done  out  1  one-cycle completion pulse
- out_valid  out  1  stream term valid (STREAM only)
- f  out  W  result/current term; equals register a
- ovf  out  1  sticky per-operation overflow; valid with done

## Operation
- Registers: a=F(k), b=F(k+1), k (NW bits), captured i, captured mode, ovf.
- IDLE: ready=1. If start, then a←seed0, b←seed1, k←0, ovf←0. Next state is CALC (mode 0) or STREAM (mode 1). A start seen in any other state is ignored.
- CALC: if k==i, go to DONE. Otherwise a←b, b←a+b (W-bit wrap), k←k+1.
- STREAM: out_valid=1, f=a=F(k). On out_valid&out_ready: if k==i, go to DONE; otherwise advance exactly as in CALC. Without a handshake, hold all registers.
- Overflow: when advancing at index k, if carry-out of a+b is 1 and k+2 ≤ i, set ovf. Carries from the unused look-ahead term F(i+1) never set ovf.
- DONE: done=1 for exactly one cycle, f=F(i), then go to IDLE. In single mode, f and ovf hold until the next accepted start.
- abort in CALC/STREAM: go to IDLE next edge, no done, ovf cleared. start together with abort in IDLE is accepted.
- rst=0 at an edge forces IDLE regardless of state: a=b=k=0, ovf=0. The register k never wraps because k ≤ i < 2^NW.

## Timing
- Reset values: ready=1, busy=0, done=0, out_valid=0, f=0, ovf=0.
- Outputs are decoded from registered state with no input-to-output combinational path, except that out_valid does not depend on out_ready.
- Single mode: start accepted at edge 0. CALC occupies cycles 1..i+1 and done is high in cycle i+2, so latency is i+2 cycles. For i=0, done is in cycle 2 with f=seed0.
- Stream mode: the first term is valid in cycle 1. Terms advance one per handshake, so full throughput is 1 term/cycle. done comes the cycle after the handshake of F(i).
- ready returns the cycle after done, or after abort. Back-to-back operations therefore have a 1-cycle IDLE gap.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values and no done.

## Structure
- Package fib_pkg holds:
  - state encoding IDLE, CALC, STREAM, DONE as a 2-bit enum;
  - MODE_SINGLE=1'b0 and MODE_STREAM=1'b1.
- One sub-module, fib_step: a combinational W-bit adder producing {carry, a+b}. It is reused wherever a wider-term variant is instantiated.
- The top level holds the FSM, registers and handshake logic.

## Test plan
- Single mode, seeds 0/1, i=10 → done in cycle 12, f=55, ovf=0. i=0 → f=0 at cycle 2. i=1 → f=1 at cycle 3.
- Single mode, Lucas seeds 2/1, i=5 → f=11. Then seeds 3/3, i=4 → f=15. start pulsed while busy is ignored.
- Stream mode, seeds 0/1, i=4, out_ready toggling 1,0,1,0… → terms 0,1,1,2,3 each emitted once, held while out_ready=0, then a single done pulse.
- Overflow, W=20, seeds 0/1:
  - i=30 → f=832040, ovf=0.
  - i=31 → f=297693 (1346269 mod 2^20), ovf=1.
- abort at cycle 5 of an i=20 single run → IDLE next cycle, no done, ready=1. A new start with i=7 → f=13.
- rst=0 for 1 cycle mid-STREAM → next cycle all outputs at reset values. A new start then completes normally.
